// File: rtl/nms_stream.sv
// nms_stream: streaming 3x3 non-maximum suppression with two line buffers and valid/ready on both sides.
// Optional feature macro NMS_LOW_THRESH_EN adds a low_thresh input that zeroes kept pixels below it.

module nms_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int MAG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [1:0]       in_dir,
`ifdef NMS_LOW_THRESH_EN
  input  logic [MAG_W-1:0] low_thresh,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_mag,
  output logic             frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = MAG_W + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

  state_t state_q, state_d;

  logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic          out_valid_q, out_valid_d;
  logic [MAG_W-1:0] out_mag_q, out_mag_d;
  logic          frame_done_q, frame_done_d;

  logic [PW-1:0] win_q [3][3];
  logic [PW-1:0] win_d [3][3];
  logic [PW-1:0] nwin  [3][3];

  // Pixels are stored as {mag, dir}; lb0 holds the previous line, lb1 the one before it.
  logic [PW-1:0] lb0_mem [IMG_W];
  logic [PW-1:0] lb1_mem [IMG_W];

  logic in_acc, out_free, out_hs, flush_loaded, fill_last, frame_last;
  logic load, done_evt;
  logic [PW-1:0] pix_in, rd0, rd1, centre;
  logic [MAG_W-1:0] c_mag, a_mag, b_mag, nms_val;
  logic [1:0] sector;
  logic keep, boundary;

  assign in_acc       = in_valid && in_ready;
  assign out_free     = !out_valid_q || out_ready;
  assign out_hs       = out_valid_q && out_ready;
  assign flush_loaded = (out_row_q == '0) && (out_col_q == '0);
  assign fill_last    = (in_row_q == ROW_ONE) && (in_col_q == '0);
  assign frame_last   = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (in_acc && fill_last) state_d = S_RUN;
      S_RUN:   if (in_acc && frame_last) state_d = S_FLUSH;
      S_FLUSH: if (flush_loaded && out_hs) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    done_evt = 1'b0;
    case (state_q)
      S_FILL: in_ready = 1'b1;
      S_RUN: begin
        in_ready = out_free;
        load     = in_valid && out_free;
      end
      S_FLUSH: begin
        load     = out_free && !flush_loaded;
        done_evt = flush_loaded && out_hs;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Window as it will look after this acceptance; the output is computed from it directly.
  always_comb begin
    pix_in = {in_mag, in_dir};
    rd0    = lb0_mem[in_col_q];
    rd1    = lb1_mem[in_col_q];
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win_q[r][1];
      nwin[r][1] = win_q[r][2];
    end
    nwin[0][2] = rd1;
    nwin[1][2] = rd0;
    nwin[2][2] = pix_in;

    centre = nwin[1][1];
    c_mag  = centre[PW-1:2];
    sector = centre[1:0];
    case (sector)
      2'd0: begin a_mag = nwin[1][0][PW-1:2]; b_mag = nwin[1][2][PW-1:2]; end
      2'd1: begin a_mag = nwin[2][0][PW-1:2]; b_mag = nwin[0][2][PW-1:2]; end
      2'd2: begin a_mag = nwin[0][1][PW-1:2]; b_mag = nwin[2][1][PW-1:2]; end
      default: begin a_mag = nwin[0][0][PW-1:2]; b_mag = nwin[2][2][PW-1:2]; end
    endcase

    keep = (c_mag >= a_mag) && (c_mag >= b_mag);
`ifdef NMS_LOW_THRESH_EN
    keep = keep && (c_mag >= low_thresh);
`endif
    boundary = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
               (out_col_q == '0) || (out_col_q == COL_LAST);
    nms_val  = (keep && !boundary) ? c_mag : '0;
  end

  always_comb begin
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    out_valid_d  = out_valid_q;
    out_mag_d    = out_mag_q;
    frame_done_d = done_evt;
    win_d        = win_q;

    if (in_acc) begin
      win_d = nwin;
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_ONE;
      end else begin
        in_col_d = in_col_q + COL_ONE;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_mag_d   = (state_q == S_RUN) ? nms_val : '0;
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ROW_ONE;
      end else begin
        out_col_d = out_col_q + COL_ONE;
      end
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (done_evt) begin
      in_col_d  = '0;
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      out_valid_q  <= 1'b0;
      out_mag_q    <= '0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      out_valid_q  <= out_valid_d;
      out_mag_q    <= out_mag_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers are never cleared: only boundary pixels can see stale contents.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      lb1_mem[in_col_q] <= rd0;
      lb0_mem[in_col_q] <= pix_in;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_mag    = out_mag_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nms_stream.sv
// Self-checking bench for nms_stream: table-driven 5x5 frames plus back-pressure and mid-frame reset sequences.
// Works with or without NMS_LOW_THRESH_EN defined.

module tb_nms_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [15:0] in_mag;
  logic [1:0]  in_dir;
  logic        out_ready;
`ifdef NMS_LOW_THRESH_EN
  logic [15:0] thr;
`endif

  logic iv5, ir5, ov5, fd5, iv8, ir8, ov8, fd8;
  logic [15:0] om5, om8;
  logic in_ready, out_valid, frame_done;
  logic [15:0] out_mag;

  assign iv5        = in_valid && !sel;
  assign iv8        = in_valid && sel;
  assign in_ready   = sel ? ir8 : ir5;
  assign out_valid  = sel ? ov8 : ov5;
  assign out_mag    = sel ? om8 : om5;
  assign frame_done = sel ? fd8 : fd5;

  nms_stream #(.IMG_W(5), .IMG_H(5), .MAG_W(16)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_mag(in_mag), .in_dir(in_dir),
`ifdef NMS_LOW_THRESH_EN
    .low_thresh(thr),
`endif
    .out_valid(ov5), .out_ready(out_ready), .out_mag(om5), .frame_done(fd5)
  );

  nms_stream #(.IMG_W(8), .IMG_H(6), .MAG_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_mag(in_mag), .in_dir(in_dir),
`ifdef NMS_LOW_THRESH_EN
    .low_thresh(thr),
`endif
    .out_valid(ov8), .out_ready(out_ready), .out_mag(om8), .frame_done(fd8)
  );

  typedef struct {
    int test;
    int r;
    int c;
    int exp;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  logic [15:0] pm   [64];
  logic [1:0]  pd   [64];
  logic [15:0] got  [64];
  logic [15:0] refa [64];
  logic [15:0] expm [64];
  int nout, fd_cnt, first_valid_idx, cyc_last_in;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int t, input int r, input int c, input int e);
    vec_t v;
    v.test = t; v.r = r; v.c = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic set_pattern(input int pat, input int w, input int h, input logic [1:0] dir);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        pd[r*w+c] = dir;
        case (pat)
          0: pm[r*w+c] = (r == 2 && c == 2) ? 16'd100 : 16'd10;
          1: pm[r*w+c] = 16'(10 * c);
          2: pm[r*w+c] = ((r == 1 && c == 3) || (r == 3 && c == 1)) ? 16'd50 :
                         (r == 2 && c == 2) ? 16'd40 : 16'd0;
          default: begin
            pm[r*w+c] = 16'((c * 37 + r * 11) % 64);
            pd[r*w+c] = 2'((r + 2 * c) % 4);
          end
        endcase
      end
  endtask

  // Reference NMS on the whole stored frame.
  task automatic model(input int w, input int h);
    int a, b, cm;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        expm[r*w+c] = 16'd0;
        if (r > 0 && r < h-1 && c > 0 && c < w-1) begin
          cm = int'(pm[r*w+c]);
          case (pd[r*w+c])
            2'd0: begin a = int'(pm[r*w+c-1]);     b = int'(pm[r*w+c+1]); end
            2'd1: begin a = int'(pm[(r+1)*w+c-1]); b = int'(pm[(r-1)*w+c+1]); end
            2'd2: begin a = int'(pm[(r-1)*w+c]);   b = int'(pm[(r+1)*w+c]); end
            default: begin a = int'(pm[(r-1)*w+c-1]); b = int'(pm[(r+1)*w+c+1]); end
          endcase
`ifdef NMS_LOW_THRESH_EN
          if (cm >= a && cm >= b && cm >= int'(thr)) expm[r*w+c] = pm[r*w+c];
`else
          if (cm >= a && cm >= b) expm[r*w+c] = pm[r*w+c];
`endif
        end
      end
  endtask

  task automatic run_frame(input int w, input int h, input bit rnd);
    int n, idx, cyc, tail;
    logic prev_stall;
    logic [15:0] prev_mag;
    n = w * h; idx = 0; cyc = 0; tail = 0;
    nout = 0; fd_cnt = 0; first_valid_idx = -1; cyc_last_in = -1;
    prev_stall = 1'b0; prev_mag = 16'd0;
    while ((nout < n || tail < 3) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (nout >= n) tail++;
      if (frame_done) fd_cnt++;
      if (out_valid && first_valid_idx < 0) first_valid_idx = idx;
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_mag", int'(out_mag), int'(prev_mag));
      end
      in_valid = (idx < n);
      if (idx < n) begin
        in_mag = pm[idx];
        in_dir = pd[idx];
      end
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (out_valid && !out_ready) check("bp_in_ready", int'(in_ready), 0);
      prev_stall = out_valid && !out_ready;
      prev_mag   = out_mag;
      if (in_valid && in_ready) begin
        idx++;
        if (idx == n) cyc_last_in = cyc;
      end
      if (out_valid && out_ready) begin
        if (nout < 64) got[nout] = out_mag;
        nout++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("out_count", nout, n);
    check("frame_done_cnt", fd_cnt, 1);
  endtask

  task automatic check_table(input int t);
    foreach (vecs[i])
      if (vecs[i].test == t)
        check($sformatf("t%0d_r%0dc%0d", t, vecs[i].r, vecs[i].c),
              int'(got[vecs[i].r*5 + vecs[i].c]), vecs[i].exp);
  endtask

  initial begin
    int idx, cyc, fdp;

    // Spike, sector 0
    add_vec(0, 2, 2, 100); add_vec(0, 2, 1, 0);  add_vec(0, 2, 3, 0);
    add_vec(0, 1, 1, 10);  add_vec(0, 1, 2, 10); add_vec(0, 3, 3, 10);
    add_vec(0, 3, 2, 10);
    // Ramp, sector 0: each interior pixel has a larger east neighbour
    add_vec(1, 1, 1, 0); add_vec(1, 2, 2, 0); add_vec(1, 2, 3, 0);
    add_vec(1, 3, 3, 0); add_vec(1, 3, 1, 0); add_vec(1, 1, 4, 0);
    // Ramp, sector 2: vertical ties are kept
    add_vec(2, 1, 1, 10); add_vec(2, 2, 2, 20); add_vec(2, 3, 3, 30);
    add_vec(2, 1, 3, 30); add_vec(2, 3, 1, 10); add_vec(2, 0, 2, 0);
    add_vec(2, 4, 2, 0);
    // Diagonal, sector 1 then sector 3
    add_vec(3, 2, 2, 0);  add_vec(3, 1, 3, 50); add_vec(3, 3, 1, 50); add_vec(3, 1, 1, 0);
    add_vec(4, 2, 2, 40); add_vec(4, 1, 3, 50); add_vec(4, 3, 1, 50);
    // Spike after mid-frame reset
    add_vec(5, 2, 2, 100); add_vec(5, 2, 1, 0); add_vec(5, 1, 1, 10); add_vec(5, 0, 0, 0);
`ifdef NMS_LOW_THRESH_EN
    add_vec(6, 2, 2, 0);   add_vec(6, 1, 1, 0);
    add_vec(7, 2, 2, 100); add_vec(7, 1, 1, 0);
    thr = 16'd0;
`endif

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_mag = '0; in_dir = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_mag", int'(out_mag), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    set_pattern(0, 5, 5, 2'd0);
    run_frame(5, 5, 1'b0);
    check("latency_first_valid_idx", first_valid_idx, 7);
    check("throughput_last_in_cycle", cyc_last_in, 25);
    check_table(0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r == 0 || r == 4 || c == 0 || c == 4)
          check($sformatf("spike_boundary_r%0dc%0d", r, c), int'(got[r*5+c]), 0);

    set_pattern(1, 5, 5, 2'd0); run_frame(5, 5, 1'b0); check_table(1);
    set_pattern(1, 5, 5, 2'd2); run_frame(5, 5, 1'b0); check_table(2);
    set_pattern(2, 5, 5, 2'd1); run_frame(5, 5, 1'b0); check_table(3);
    set_pattern(2, 5, 5, 2'd3); run_frame(5, 5, 1'b0); check_table(4);

    // Mid-frame reset: 13 inputs of a ramp frame, then reset, then a full spike frame
    set_pattern(1, 5, 5, 2'd0);
    idx = 0; cyc = 0; fdp = 0;
    while (idx < 13 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (frame_done) fdp++;
      in_valid = 1'b1; in_mag = pm[idx]; in_dir = pd[idx]; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) idx++;
    end
    check("partial_inputs", idx, 13);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    if (frame_done) fdp++;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    check("partial_no_frame_done", fdp, 0);
    set_pattern(0, 5, 5, 2'd0);
    run_frame(5, 5, 1'b0);
    check_table(5);

`ifdef NMS_LOW_THRESH_EN
    thr = 16'd101; run_frame(5, 5, 1'b0); check_table(6);
    thr = 16'd100; run_frame(5, 5, 1'b0); check_table(7);
    thr = 16'd0;
`endif

    // Back-pressure on the 8x6 instance: reference run, then random out_ready
    sel = 1'b1;
    set_pattern(3, 8, 6, 2'd0);
    model(8, 6);
    run_frame(8, 6, 1'b0);
    for (int i = 0; i < 48; i++) begin
      check($sformatf("bp_ref_%0d", i), int'(got[i]), int'(expm[i]));
      refa[i] = got[i];
    end
    run_frame(8, 6, 1'b1);
    for (int i = 0; i < 48; i++)
      check($sformatf("bp_rand_%0d", i), int'(got[i]), int'(refa[i]));
    run_frame(8, 6, 1'b1);
    for (int i = 0; i < 48; i++)
      check($sformatf("bp_rand2_%0d", i), int'(got[i]), int'(expm[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
